mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Parametrised memory/writeback stage of the TinyRisc-V core, between decode_execute and the register file. Accepts one instruction per valid/ready handshake and runs loads/stores over a variable-latency req/ack data-memory port. Handles byte/half/word (and double for XLEN=64) lane steering, load sign/zero extension and register writeback. Pulses `done` to the controller on each retirement.

## Interface
- `XLEN`, 32, data/address width; legal values 32 or 64
- `RD_W`, 5, register-number width
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous and active-high
- `in_valid`  in  1  instruction presented by decode_execute
- `in_ready`  out  1  stage can accept
- `opcode`  in  7  RISC-V opcode
- `func3`  in  3  width/sign select
- `wb_reg`  in  1  instruction writes rd
- `rd_num`  in  RD_W  destination register
- `alu_out`  in  XLEN  ALU result / effective address
- `rs2_data`  in  XLEN  store data
- `dmem_req`  out  1  memory request
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  XLEN  aligned address (low log2(XLEN/8) bits zero)
- `dmem_be`  out  XLEN/8  byte enables
- `dmem_wdata`  out  XLEN  lane-steered store data
- `dmem_ack`  in  1  request complete; rdata valid same cycle for loads
- `dmem_rdata`  in  XLEN  load data
- `wb_enable`  out  1  register-file write strobe
- `wb_rd_num`  out  RD_W  write register
- `wb_rd_data`  out  XLEN  write data
- `done`  out  1  one-cycle retirement pulse
- `misalign`  out  1  misaligned-access pulse (see Configuration)

## Operation
- FSM states: IDLE, MEM, WB. Reset → IDLE.
- `in_ready` = (state != MEM) and not `rst`. Accept = `in_valid & in_ready` at rising edge; accepted fields are captured into internal registers.
- Accepted load (0000011) or store (0100011) → MEM; any other opcode → WB.
- MEM: `dmem_req`=1; `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata` held stable from captured values until `dmem_ack` sampled 1. Then → WB, with load data captured. `in_valid` is ignored in MEM.
- WB: `done`=1; `wb_enable` = captured `wb_reg` and rd != 0, and not a store; `wb_rd_num` = captured rd. Without an accept → IDLE; with an accept → MEM or WB per the new opcode (back-to-back ALU ops retire 1 per cycle).
- Offset `off` = `alu_out[log2(XLEN/8)-1:0]`.
- Size from `func3[1:0]`: 00 byte, 01 half, 10 word, 11 double (XLEN=64 only; illegal at 32 → treated as word).
- `dmem_be` = size mask << `off`, truncated to XLEN/8 bits.
- `dmem_wdata` = `rs2_data` << (8*off).
- Load result = `dmem_rdata` >> (8*off), masked to size. `func3[2]`=0 sign-extends, 1 zero-extends (LBU/LHU/LWU).
- Non-memory `wb_rd_data` = captured `alu_out`.
- Outside WB: `wb_enable`, `done`, `wb_rd_data`, `wb_rd_num` are 0.

## Timing
- Reset values: all outputs 0, including `in_ready` while `rst`=1; state IDLE.
- ALU op: accept at edge N; WB (`done`, `wb_enable`) during cycle N+1.
- Memory op: accept at edge N; `dmem_req` high from cycle N+1. Ack may arrive in that same first cycle. Ack sampled at edge M → WB during cycle M+1. Minimum latency 2 cycles.
- `dmem_ack` outside MEM is ignored.
- `rst` mid-MEM: `dmem_req` drops asynchronously and the instruction is discarded with no `done`. A subsequent stale ack is ignored.
- `done` is never high for two consecutive cycles for the same instruction.

## Configuration
- `MEM_WB_MISALIGN_TRAP_EN` defined:
  - A load/store is misaligned when `off` is not a multiple of its size.
  - A misaligned load/store goes directly to WB with no `dmem_req`; `wb_enable`=0, `done`=1, `misalign`=1 for that one cycle.
- Undefined:
  - `misalign` is tied to 0.
  - Misaligned accesses issue normally with truncated `dmem_be`; bytes beyond the word are dropped and, for loads, read as zero before extension.

## Test plan
- ADD, rd=5, `alu_out`=0x1234, `wb_reg`=1 → next cycle `wb_enable`=1, `wb_rd_num`=5, `wb_rd_data`=0x1234, `done`=1; no `dmem_req`.
- LB at `alu_out`=0x103, `dmem_rdata`=0x80FF_FFFF, ack after 3 cycles → `dmem_addr`=0x100, `dmem_be`=1000b; `wb_rd_data`=0xFFFF_FF80; with LBU → 0x0000_0080.
- SH at 0x202, `rs2_data`=0xAAAA_BEEF → `dmem_we`=1, `dmem_be`=1100b, `dmem_wdata`=0xBEEF_xxxx (upper half 0xBEEF); `wb_enable`=0, `done`=1.
- Four back-to-back ALU ops with `in_valid` held high → `in_ready` stays 1 and `done` is high for 4 consecutive cycles; rd=0 → `wb_enable`=0.
- Load in MEM, assert `rst` before ack, then ack after release → no `done`, no write, state IDLE.
- Macro on: LW at 0x102 → `misalign`=1, `done`=1, no `dmem_req`. Macro off: `dmem_be`=1100b and the access completes normally.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: one instruction per handshake, variable-latency dmem port, byte-lane steering.
// Define MEM_WB_MISALIGN_TRAP_EN to retire misaligned loads/stores with a misalign pulse instead of accessing memory.

module mem_wb_lane #(
  parameter int NB   = 4,
  parameter int OW   = 2,
  parameter int LANE = 0
) (
  input  logic [OW-1:0]      i_st_off,
  input  logic [OW-1:0]      i_ld_off,
  input  logic [NB-1:0][7:0] i_st_src,
  input  logic [NB-1:0][7:0] i_ld_src,
  output logic [7:0]         o_st_byte,
  output logic [7:0]         o_ld_byte
);
  localparam logic [OW:0] L = (OW+1)'(LANE);
  logic [OW:0] w_st_idx, w_ld_idx;
  assign w_st_idx = L - {1'b0, i_st_off};
  assign w_ld_idx = L + {1'b0, i_ld_off};
  // A borrow/carry in the extra bit means the source byte falls outside the word.
  assign o_st_byte = w_st_idx[OW] ? 8'h00 : i_st_src[w_st_idx[OW-1:0]];
  assign o_ld_byte = w_ld_idx[OW] ? 8'h00 : i_ld_src[w_ld_idx[OW-1:0]];
endmodule

module mem_wb_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic              wb_reg,
  input  logic [RD_W-1:0]   rd_num,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_enable,
  output logic [RD_W-1:0]   wb_rd_num,
  output logic [XLEN-1:0]   wb_rd_data,
  output logic              done,
  output logic              misalign
);
  localparam int NB = XLEN/8;
  localparam int OW = $clog2(NB);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_t;
  state_t r_state;

  logic                r_dmem_req, r_dmem_we;
  logic [XLEN-1:0]     r_dmem_addr, r_dmem_wdata;
  logic [NB-1:0]       r_dmem_be;
  logic                r_wb_enable, r_done;
  logic [RD_W-1:0]     r_wb_rd_num, r_rd;
  logic [XLEN-1:0]     r_wb_rd_data;
  logic                r_wb_reg, r_store;
  logic [2:0]          r_func3;
  logic [OW-1:0]       r_off;

  logic                w_accept, w_is_mem, w_is_store, w_misal;
  logic [OW-1:0]       w_off;
  logic [NB-1:0]       w_mask, w_be;
  logic [NB-1:0][7:0]  w_wdata, w_ld_shift;
  logic [XLEN-1:0]     w_ld_keep, w_ld_result;
  logic                w_ld_sign;

  function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = NB'(1);
      2'b01:   size_mask = NB'(3);
      2'b10:   size_mask = NB'(15);
      default: size_mask = (XLEN == 64) ? '1 : NB'(15);
    endcase
  endfunction

  assign in_ready   = (r_state != S_MEM) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_is_store = (opcode == OP_STORE);
  assign w_is_mem   = (opcode == OP_LOAD) || w_is_store;
  assign w_off      = alu_out[OW-1:0];
  assign w_mask     = size_mask(func3[1:0]);
  assign w_be       = w_mask << w_off;

  // Store data is steered at accept time; load data uses the captured offset.
  for (genvar g = 0; g < NB; g++) begin : g_lane
    mem_wb_lane #(.NB(NB), .OW(OW), .LANE(g)) u_lane (
      .i_st_off  (w_off),
      .i_ld_off  (r_off),
      .i_st_src  (rs2_data),
      .i_ld_src  (dmem_rdata),
      .o_st_byte (w_wdata[g]),
      .o_ld_byte (w_ld_shift[g])
    );
  end

  always_comb begin
    w_ld_keep = XLEN'(32'hFFFF_FFFF);
    w_ld_sign = w_ld_shift[3][7];
    case (r_func3[1:0])
      2'b00: begin w_ld_keep = XLEN'(8'hFF);   w_ld_sign = w_ld_shift[0][7]; end
      2'b01: begin w_ld_keep = XLEN'(16'hFFFF); w_ld_sign = w_ld_shift[1][7]; end
      2'b10: ;
      default: if (XLEN == 64) begin
        w_ld_keep = '1;
        w_ld_sign = w_ld_shift[NB-1][7];
      end
    endcase
    w_ld_result = (w_ld_shift & w_ld_keep) | ((w_ld_sign && !r_func3[2]) ? ~w_ld_keep : '0);
  end

`ifdef MEM_WB_MISALIGN_TRAP_EN
  function automatic logic [OW-1:0] align_bits(input logic [1:0] sz);
    case (sz)
      2'b00:   align_bits = '0;
      2'b01:   align_bits = OW'(1);
      2'b10:   align_bits = OW'(3);
      default: align_bits = (XLEN == 64) ? OW'(7) : OW'(3);
    endcase
  endfunction

  logic r_misalign;
  assign w_misal = w_is_mem && ((w_off & align_bits(func3[1:0])) != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_accept && w_misal;
  end
  assign misalign = r_misalign;
`else
  assign w_misal  = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_be    <= '0;
      r_dmem_wdata <= '0;
      r_wb_enable  <= 1'b0;
      r_done       <= 1'b0;
      r_wb_rd_num  <= '0;
      r_wb_rd_data <= '0;
      r_wb_reg     <= 1'b0;
      r_store      <= 1'b0;
      r_rd         <= '0;
      r_func3      <= '0;
      r_off        <= '0;
    end else begin
      r_done       <= 1'b0;
      r_wb_enable  <= 1'b0;
      r_wb_rd_num  <= '0;
      r_wb_rd_data <= '0;
      case (r_state)
        S_MEM: if (dmem_ack) begin
          r_state      <= S_WB;
          r_dmem_req   <= 1'b0;
          r_dmem_we    <= 1'b0;
          r_dmem_addr  <= '0;
          r_dmem_be    <= '0;
          r_dmem_wdata <= '0;
          r_done       <= 1'b1;
          r_wb_enable  <= r_wb_reg && (r_rd != '0) && !r_store;
          r_wb_rd_num  <= r_rd;
          r_wb_rd_data <= r_store ? '0 : w_ld_result;
        end
        default: if (w_accept) begin
          r_wb_reg <= wb_reg;
          r_rd     <= rd_num;
          r_func3  <= func3;
          r_off    <= w_off;
          r_store  <= w_is_store;
          if (w_is_mem && !w_misal) begin
            r_state      <= S_MEM;
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= w_is_store;
            r_dmem_addr  <= {alu_out[XLEN-1:OW], {OW{1'b0}}};
            r_dmem_be    <= w_be;
            r_dmem_wdata <= w_wdata;
          end else begin
            // ALU ops and trapped misaligned accesses retire directly.
            r_state      <= S_WB;
            r_done       <= 1'b1;
            r_wb_enable  <= !w_is_mem && wb_reg && (rd_num != '0);
            r_wb_rd_num  <= rd_num;
            r_wb_rd_data <= w_is_mem ? '0 : alu_out;
          end
        end else begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_be    = r_dmem_be;
  assign dmem_wdata = r_dmem_wdata;
  assign wb_enable  = r_wb_enable;
  assign wb_rd_num  = r_wb_rd_num;
  assign wb_rd_data = r_wb_rd_data;
  assign done       = r_done;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected retirements queued at issue, popped on done.
// Memory handshake fields are checked by the responder task against constants.

module tb_mem_wb_stage;
  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam int NB   = XLEN/8;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6:0]      opcode = '0;
  logic [2:0]      func3 = '0;
  logic            wb_reg = 1'b0;
  logic [RD_W-1:0] rd_num = '0;
  logic [XLEN-1:0] alu_out = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic            dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata;
  logic [NB-1:0]   dmem_be;
  logic            dmem_ack = 1'b0;
  logic [XLEN-1:0] dmem_rdata = '0;
  logic            wb_enable, done, misalign;
  logic [RD_W-1:0] wb_rd_num;
  logic [XLEN-1:0] wb_rd_data;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .wb_reg(wb_reg), .rd_num(rd_num),
    .alu_out(alu_out), .rs2_data(rs2_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_enable(wb_enable), .wb_rd_num(wb_rd_num), .wb_rd_data(wb_rd_data),
    .done(done), .misalign(misalign)
  );

  typedef struct {
    logic            en;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic            dchk;
    logic            mis;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;
  int   req_cycles = 0, done_run = 0, max_run = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic en, input logic [RD_W-1:0] rd,
                              input logic [XLEN-1:0] data, input logic dchk, input logic mis);
    exp_t e;
    e.en = en; e.rd = rd; e.data = data; e.dchk = dchk; e.mis = mis;
    return e;
  endfunction

  always @(negedge clk) begin
    if (dmem_req) req_cycles++;
    if (done) begin
      done_run++;
      if (done_run > max_run) max_run = done_run;
      if (sb.size() == 0) chk("unexp_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("wb_en", wb_enable, mon_e.en);
        chk("wb_rd", wb_rd_num, mon_e.rd);
        if (mon_e.dchk) chk("wb_data", wb_rd_data, mon_e.data);
        chk("misalign", misalign, mon_e.mis);
      end
    end else begin
      done_run = 0;
    end
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic wbr,
                       input logic [RD_W-1:0] rd, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rs2);
    opcode = op; func3 = f3; wb_reg = wbr; rd_num = rd; alu_out = alu; rs2_data = rs2;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic wbr,
                       input logic [RD_W-1:0] rd, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rs2,
                       input logic push, input exp_t e);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    chk("issue_ready", in_ready, 1);
    drive(op, f3, wbr, rd, alu, rs2);
    in_valid = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic mem_resp(input logic we, input logic [XLEN-1:0] addr, input logic [NB-1:0] be,
                          input logic [XLEN-1:0] wd, input logic wd_chk, input int lat,
                          input logic [XLEN-1:0] rdata);
    int t = 0;
    @(negedge clk);
    while (!dmem_req && t < 20) begin @(negedge clk); t++; end
    chk("req_seen", dmem_req, 1);
    if (dmem_req) begin
      chk("dmem_we", dmem_we, we);
      chk("dmem_addr", dmem_addr, addr);
      chk("dmem_be", dmem_be, be);
      if (wd_chk) chk("dmem_wdata", dmem_wdata, wd);
      for (int i = 0; i < lat; i++) @(negedge clk);
      if (lat > 0) begin
        chk("req_hold", dmem_req, 1);
        chk("addr_hold", dmem_addr, addr);
      end
      dmem_ack = 1'b1; dmem_rdata = rdata;
      @(posedge clk);
      #1 dmem_ack = 1'b0; dmem_rdata = $urandom;
    end
  endtask

  int r0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_wb_en", wb_enable, 0);
    chk("rst_wb_data", wb_rd_data, 0);
    chk("rst_misalign", misalign, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    // ADD rd=5
    r0 = req_cycles;
    issue(OP_ALU, 3'b000, 1'b1, 5'd5, 32'h1234, '0, 1'b1, mk(1'b1, 5'd5, 32'h1234, 1'b1, 1'b0));
    repeat (2) @(negedge clk);
    chk("alu_no_req", req_cycles, r0);

    // LB / LBU at 0x103
    issue(OP_LOAD, 3'b000, 1'b1, 5'd7, 32'h103, '0, 1'b1, mk(1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0));
    mem_resp(1'b0, 32'h100, 4'b1000, '0, 1'b0, 3, 32'h80FF_FFFF);
    issue(OP_LOAD, 3'b100, 1'b1, 5'd8, 32'h103, '0, 1'b1, mk(1'b1, 5'd8, 32'h0000_0080, 1'b1, 1'b0));
    mem_resp(1'b0, 32'h100, 4'b1000, '0, 1'b0, 0, 32'h80FF_FFFF);

    // SH at 0x202
    issue(OP_STORE, 3'b001, 1'b1, 5'd9, 32'h202, 32'hAAAA_BEEF, 1'b1, mk(1'b0, 5'd9, '0, 1'b0, 1'b0));
    mem_resp(1'b1, 32'h200, 4'b1100, 32'hBEEF_0000, 1'b1, 1, $urandom);

    // LH at 0x202, sign-extended
    issue(OP_LOAD, 3'b001, 1'b1, 5'd10, 32'h202, '0, 1'b1, mk(1'b1, 5'd10, 32'hFFFF_8001, 1'b1, 1'b0));
    mem_resp(1'b0, 32'h200, 4'b1100, '0, 1'b0, 2, 32'h8001_0000);

    // LW at 0x102
`ifdef MEM_WB_MISALIGN_TRAP_EN
    r0 = req_cycles;
    issue(OP_LOAD, 3'b010, 1'b1, 5'd11, 32'h102, '0, 1'b1, mk(1'b0, 5'd11, '0, 1'b0, 1'b1));
    repeat (3) @(negedge clk);
    chk("misal_no_req", req_cycles, r0);
`else
    issue(OP_LOAD, 3'b010, 1'b1, 5'd11, 32'h102, '0, 1'b1, mk(1'b1, 5'd11, 32'h0000_1234, 1'b1, 1'b0));
    mem_resp(1'b0, 32'h100, 4'b1100, '0, 1'b0, 1, 32'h1234_5678);
    repeat (2) @(negedge clk);
`endif

    // Four back-to-back ALU ops, third one with rd=0
    max_run = 0;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(OP_ALU, 3'b000, 1'b1, (i == 2) ? 5'd0 : RD_W'(i + 1), 32'h1000 + XLEN'(i), '0);
      sb.push_back(mk((i != 2), (i == 2) ? 5'd0 : RD_W'(i + 1), 32'h1000 + XLEN'(i), 1'b1, 1'b0));
      chk("b2b_ready", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_run", max_run, 4);

    // Reset during MEM, then a stale ack
    issue(OP_LOAD, 3'b010, 1'b1, 5'd12, 32'h300, '0, 1'b0, mk(1'b0, '0, '0, 1'b0, 1'b0));
    @(negedge clk);
    chk("rst_mid_req_pre", dmem_req, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req_drop", dmem_req, 0);
    chk("rst_mid_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stale_req", dmem_req, 0);
    chk("stale_ready", in_ready, 1);
    chk("stale_wb_en", wb_enable, 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
